ddr_access_arbiter: RTL
=======================

Name: ddr_access_arbiter

Overview:
- Shares the single MIG user (app_*) port between two requesters, all in the ui_clk domain.
- Write requester: the packed-pixel path fed from the UART FIFO. Read requester: the frame reader that fills the VGA BRAM.
- Sequences each MIG command/write-data handshake and enforces burst quotas so that neither side starves.
- Tracks in-flight reads and exposes busy_read/busy_write status to the rest of the memory path.

Parameters:
- ADDR_W, 27, MIG app_addr width.
- DATA_W, 128, MIG user data width (5 packed pixels plus 1 unused byte).
- BURST_MAX, 8, maximum consecutive grants to one requester while the other is waiting (1..255).
- MAX_RD_OUT, 16, maximum reads issued but not yet returned (1..255).

Ports:
- clk  in  1  ui_clk from the MIG.
- cpu_resetn  in  1  asynchronous reset, active-low.
- init_calib_complete  in  1  MIG calibration done.
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_gnt.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  1-cycle pulse: write command and data both accepted by the MIG.
- rd_req  in  1  read request; held with rd_addr until rd_gnt.
- rd_addr  in  ADDR_W  read address.
- rd_gnt  out  1  1-cycle pulse: read command accepted.
- rd_data  out  DATA_W  registered copy of app_rd_data.
- rd_valid  out  1  registered copy of app_rd_data_valid.
- busy_read  out  1  state is RD_CMD, or outstanding reads != 0.
- busy_write  out  1  state is WR_CMD.
- app_addr  out  ADDR_W  to MIG.
- app_cmd  out  3  to MIG.
- app_en  out  1  to MIG.
- app_rdy  in  1  from MIG.
- app_wdf_data  out  DATA_W  to MIG.
- app_wdf_wren  out  1  to MIG.
- app_wdf_end  out  1  to MIG.
- app_wdf_rdy  in  1  from MIG.
- app_rd_data  in  DATA_W  from MIG.
- app_rd_data_valid  in  1  from MIG.
- app_rd_data_end  in  1  from MIG.
- perf_wr_cnt  out  32  write grant count (ARB_PERF_CNT_EN).
- perf_rd_cnt  out  32  read grant count (ARB_PERF_CNT_EN).
- perf_stall_cnt  out  32  stall cycle count (ARB_PERF_CNT_EN).

Behaviour:
- Reset: all outputs 0; state CALIB; owner=READ; burst_cnt=0; rd_out=0.
- FSM states: CALIB, IDLE, WR_CMD, RD_CMD.
- CALIB -> IDLE once init_calib_complete=1. No grants are issued in CALIB.
- Arbitration in IDLE, one decision per cycle:
  - Read is eligible when rd_req=1 and rd_out<MAX_RD_OUT.
  - Only one side eligible: grant it.
  - Both eligible: grant owner if burst_cnt<BURST_MAX; otherwise grant the other side.
  - Granting the same side: burst_cnt+1, saturating. Granting the other side: owner flips, burst_cnt=1.
  - Neither eligible: stay in IDLE; burst_cnt is held.
- Command latch: on the IDLE decision, addr/data are latched and app_* are driven from registers starting the next cycle.
- WR_CMD:
  - app_en=1 and app_cmd=3'b000 until app_rdy is seen.
  - In parallel, app_wdf_wren=app_wdf_end=1 until app_wdf_rdy is seen.
  - cmd_done and dat_done flags record each acceptance. They may complete in either order or in the same cycle.
  - When both are done: wr_gnt pulses in the cycle the last acceptance is sampled; the flags clear; state returns to IDLE.
- RD_CMD:
  - app_en=1 and app_cmd=3'b001 until app_rdy.
  - On the accepting edge: rd_gnt pulses, rd_out+1, state returns to IDLE.
- rd_out bookkeeping: decrements when app_rd_data_valid && app_rd_data_end. An increment and a decrement in the same cycle leave it unchanged. It never wraps: issue is blocked at MAX_RD_OUT.
- Read data return: rd_data/rd_valid lag the MIG by one cycle. Returns are accepted in every state, including CALIB after reset.
- Grant spacing: minimum 3 cycles from a request in IDLE to the next IDLE decision. Back-to-back grants are never issued.
- Requester contract: a requester must not drop its request before its grant. If it does, the latched command still completes.
- Reset mid-operation: all state is cleared. In-flight reads are forgotten, but their late returns still appear on rd_valid.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - perf_wr_cnt increments on each wr_gnt.
  - perf_rd_cnt increments on each rd_gnt.
  - perf_stall_cnt increments each cycle that app_en=1 and app_rdy=0.
  - All three are 32-bit, wrap at 2^32, and are cleared by reset.
- Undefined: the ports remain and are tied to 0; no counter logic is generated.

Decomposition:
- Package ddr_arb_pkg:
  - State enum {CALIB, IDLE, WR_CMD, RD_CMD}.
  - Owner enum {OWN_RD, OWN_WR}.
  - Constants MIG_CMD_WR=3'b000 and MIG_CMD_RD=3'b001.
- One natural sub-module, ddr_arb_pick: the combinational eligibility/quota decision plus the owner and burst_cnt registers.

Test Plan:
- Calibration gate: init_calib_complete held 0 with wr_req=1 for 50 cycles -> no app_en, no wr_gnt. After it rises -> app_en and app_cmd=000 within 2 cycles.
- Write handshake split: app_rdy accepts at cycle 3, app_wdf_rdy at cycle 7 -> exactly one wr_gnt at cycle 7. app_wdf_wren drops after cycle 7; app_en drops after cycle 3.
- Quota fairness: both requests held continuously, MIG always ready, BURST_MAX=8 -> grant sequence is 8 reads, 8 writes, 8 reads, ...
- Outstanding limit: MAX_RD_OUT=16 with no read returns -> 16 rd_gnt, then busy_read=1 and no further reads while writes proceed. One return with app_rd_data_end -> one more read is granted.
- Simultaneous increment/decrement: a read is accepted in the same cycle as a data return -> rd_out is unchanged, and rd_valid follows one cycle after app_rd_data_valid.
- Reset mid-operation: cpu_resetn asserted during WR_CMD with cmd_done=1 -> all outputs 0 asynchronously; after release the FSM is in CALIB and no spurious wr_gnt occurs.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types and MIG command encodings for the DDR access arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {CALIB, IDLE, WR_CMD, RD_CMD} state_e;
  typedef enum logic {OWN_RD, OWN_WR} owner_e;

  localparam logic [2:0] MIG_CMD_WR = 3'b000;
  localparam logic [2:0] MIG_CMD_RD = 3'b001;

endpackage

// File: rtl/ddr_arb_pick.sv
// Eligibility/quota decision between the write and read requesters,
// holding the current owner and its consecutive-grant count.
module ddr_arb_pick
  import ddr_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic decide,
  input  logic wr_elig,
  input  logic rd_elig,
  output logic pick_wr,
  output logic pick_rd
);

  localparam logic [7:0] BMAX = 8'(BURST_MAX);

  owner_e     owner_q, owner_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       quota_left;

  always_comb begin
    quota_left  = burst_cnt_q < BMAX;
    pick_wr     = 1'b0;
    pick_rd     = 1'b0;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (decide) begin
      if (wr_elig && rd_elig) begin
        // Owner keeps the port while quota remains; otherwise the waiter wins.
        if ((owner_q == OWN_WR) == quota_left) pick_wr = 1'b1;
        else                                    pick_rd = 1'b1;
      end else begin
        pick_wr = wr_elig;
        pick_rd = rd_elig;
      end
    end
    if (pick_wr || pick_rd) begin
      if ((owner_q == OWN_WR) == pick_wr) begin
        if (burst_cnt_q != 8'hFF) burst_cnt_d = burst_cnt_q + 8'd1;
      end else begin
        owner_d     = pick_wr ? OWN_WR : OWN_RD;
        burst_cnt_d = 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_RD;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/ddr_access_arbiter.sv
// Shares the MIG app_* port between the packed-pixel writer and the frame reader.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module ddr_access_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned BURST_MAX  = 8,
  parameter int unsigned MAX_RD_OUT = 16
) (
  input  logic              clk,
  input  logic              cpu_resetn,
  input  logic              init_calib_complete,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy_read,
  output logic              busy_write,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  input  logic              app_rd_data_end,
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_stall_cnt
);

  localparam logic [7:0] RD_LIMIT = 8'(MAX_RD_OUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cmd_done_q, cmd_done_d;
  logic              dat_done_q, dat_done_d;
  logic [7:0]        rd_out_q, rd_out_d;
  logic              pick_wr, pick_rd;
  logic              cmd_acc, dat_acc, rd_ret;

  ddr_arb_pick #(.BURST_MAX(BURST_MAX)) u_pick (
    .clk     (clk),
    .rst_n   (cpu_resetn),
    .decide  (state_q == IDLE),
    .wr_elig (wr_req),
    .rd_elig (rd_req && (rd_out_q < RD_LIMIT)),
    .pick_wr (pick_wr),
    .pick_rd (pick_rd)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cmd_done_d   = cmd_done_q;
    dat_done_d   = dat_done_q;
    app_en       = 1'b0;
    app_cmd      = MIG_CMD_WR;
    app_wdf_wren = 1'b0;
    wr_gnt       = 1'b0;
    rd_gnt       = 1'b0;
    cmd_acc      = 1'b0;
    dat_acc      = 1'b0;
    case (state_q)
      CALIB: if (init_calib_complete) state_d = IDLE;
      IDLE: begin
        if (pick_wr) begin
          state_d = WR_CMD;
          addr_d  = wr_addr;
          data_d  = wr_data;
        end else if (pick_rd) begin
          state_d = RD_CMD;
          addr_d  = rd_addr;
        end
      end
      WR_CMD: begin
        // Command and data channels complete independently, in either order.
        app_en       = !cmd_done_q;
        app_wdf_wren = !dat_done_q;
        cmd_acc      = cmd_done_q || app_rdy;
        dat_acc      = dat_done_q || app_wdf_rdy;
        cmd_done_d   = cmd_acc;
        dat_done_d   = dat_acc;
        if (cmd_acc && dat_acc) begin
          wr_gnt     = 1'b1;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          state_d    = IDLE;
        end
      end
      RD_CMD: begin
        app_en  = 1'b1;
        app_cmd = MIG_CMD_RD;
        if (app_rdy) begin
          rd_gnt  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = CALIB;
    endcase
    // Returns of reads forgotten by a reset must not underflow the count.
    rd_ret     = app_rd_data_valid && app_rd_data_end && (rd_out_q != '0);
    rd_out_d   = rd_out_q + {7'd0, rd_gnt} - {7'd0, rd_ret};
    rd_data_d  = app_rd_data;
    rd_valid_d = app_rd_data_valid;
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q    <= CALIB;
      addr_q     <= '0;
      data_q     <= '0;
      cmd_done_q <= 1'b0;
      dat_done_q <= 1'b0;
      rd_out_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cmd_done_q <= cmd_done_d;
      dat_done_q <= dat_done_d;
      rd_out_q   <= rd_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign app_addr     = addr_q;
  assign app_wdf_data = data_q;
  assign app_wdf_end  = app_wdf_wren;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign busy_read    = (state_q == RD_CMD) || (rd_out_q != '0);
  assign busy_write   = (state_q == WR_CMD);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_wr_q, perf_wr_d, perf_rd_q, perf_rd_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_wr_d    = perf_wr_q + {31'd0, wr_gnt};
    perf_rd_d    = perf_rd_q + {31'd0, rd_gnt};
    perf_stall_d = perf_stall_q + {31'd0, app_en && !app_rdy};
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      perf_wr_q    <= '0;
      perf_rd_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_wr_q    <= perf_wr_d;
      perf_rd_q    <= perf_rd_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_wr_cnt    = perf_wr_q;
  assign perf_rd_cnt    = perf_rd_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_wr_cnt    = '0;
  assign perf_rd_cnt    = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
